// File: rtl/usbfs_packet_sequencer.sv
// USB FS packet sequencer: RX bit->byte assembly, 2-cycle response window, TX byte->bit serialization.
// Outputs registered (1-cycle latency, busy combinational); no backpressure, transceiver paces TX via tx_req.
module usbfs_packet_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_sta,
    input  logic        rx_ena,
    input  logic        rx_bit,
    input  logic        rx_fin,
    output logic        tx_sta,
    input  logic        tx_req,
    output logic        tx_bit,
    output logic        tx_fin,
    output logic        rx_pkt_sta,
    output logic        rx_byte_valid,
    output logic [7:0]  rx_byte,
    output logic        rx_pkt_end,
    output logic        rx_pkt_ok,
    output logic [10:0] rx_pkt_len,
    input  logic        tx_go,
    input  logic [7:0]  tx_data,
    input  logic        tx_empty,
    output logic        tx_rd,
    output logic        tx_done,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, RX, WIN, TX, TXEND} state_t;

    state_t      state, state_nxt;
    logic [2:0]  bit_cnt;
    logic [10:0] byte_cnt;
    logic [6:0]  rx_sr;
    logic        win_cnt;
    logic [2:0]  tx_idx;
    logic [6:0]  tx_sr;
    logic        rx_start;

    assign rx_start = rx_sta && (state == IDLE || state == RX || state == WIN);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rx_sta) state_nxt = RX;
            RX:      if (rx_sta) state_nxt = RX;
                     else if (rx_fin) state_nxt = WIN;
            WIN:     if (rx_sta) state_nxt = RX;
                     else if (tx_go) state_nxt = TX;
                     else if (win_cnt) state_nxt = IDLE;
            TX:      if (tx_req && tx_idx == 3'd0 && tx_empty) state_nxt = TXEND;
            TXEND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            rx_sr         <= '0;
            win_cnt       <= 1'b0;
            tx_idx        <= '0;
            tx_sr         <= '0;
            tx_sta        <= 1'b0;
            tx_bit        <= 1'b0;
            tx_fin        <= 1'b0;
            rx_pkt_sta    <= 1'b0;
            rx_byte_valid <= 1'b0;
            rx_byte       <= '0;
            rx_pkt_end    <= 1'b0;
            rx_pkt_ok     <= 1'b0;
            rx_pkt_len    <= '0;
            tx_rd         <= 1'b0;
            tx_done       <= 1'b0;
        end else begin
            tx_sta        <= 1'b0;
            tx_fin        <= 1'b0;
            rx_pkt_sta    <= 1'b0;
            rx_byte_valid <= 1'b0;
            rx_pkt_end    <= 1'b0;
            tx_rd         <= 1'b0;
            tx_done       <= 1'b0;

            if (rx_start) begin
                bit_cnt    <= '0;
                byte_cnt   <= '0;
                rx_sr      <= '0;
                rx_pkt_sta <= 1'b1;
                // a new start while still receiving closes the old packet as bad
                if (state == RX) begin
                    rx_pkt_end <= 1'b1;
                    rx_pkt_ok  <= 1'b0;
                    rx_pkt_len <= byte_cnt;
                end
            end else begin
                case (state)
                    RX: begin
                        if (rx_fin) begin
                            rx_pkt_end <= 1'b1;
                            rx_pkt_ok  <= (bit_cnt == 3'd0) && (byte_cnt != 11'd0);
                            rx_pkt_len <= byte_cnt;
                            win_cnt    <= 1'b0;
                        end else if (rx_ena) begin
                            rx_sr   <= {rx_bit, rx_sr[6:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_byte_valid <= 1'b1;
                                rx_byte       <= {rx_bit, rx_sr};
                                if (byte_cnt != 11'd2047) byte_cnt <= byte_cnt + 11'd1;
                            end
                        end
                    end
                    WIN: begin
                        win_cnt <= 1'b1;
                        if (tx_go) begin
                            tx_sta <= 1'b1;
                            tx_idx <= '0;
                        end
                    end
                    TXEND:   tx_done <= 1'b1;
                    default: ;
                endcase
            end

            if (tx_req) begin
                if (state == TX) begin
                    if (tx_idx == 3'd0) begin
                        if (tx_empty) begin
                            tx_fin <= 1'b1;
                            tx_bit <= 1'b0;
                        end else begin
                            tx_sr  <= tx_data[7:1];
                            tx_bit <= tx_data[0];
                            tx_rd  <= 1'b1;
                            tx_idx <= 3'd1;
                        end
                    end else begin
                        tx_bit <= tx_sr[0];
                        tx_sr  <= {1'b0, tx_sr[6:1]};
                        tx_idx <= tx_idx + 3'd1;
                    end
                end else begin
                    tx_fin <= 1'b1;
                    tx_bit <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_usbfs_packet_sequencer.sv
// Directed bench for usbfs_packet_sequencer with RX-byte and TX-bit scoreboards.
module tb_usbfs_packet_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_sta, rx_ena, rx_bit, rx_fin;
    logic        tx_sta, tx_req, tx_bit, tx_fin;
    logic        rx_pkt_sta, rx_byte_valid;
    logic [7:0]  rx_byte;
    logic        rx_pkt_end, rx_pkt_ok;
    logic [10:0] rx_pkt_len;
    logic        tx_go;
    logic [7:0]  tx_data;
    logic        tx_empty;
    logic        tx_rd, tx_done, busy;

    int checks = 0;
    int failures = 0;
    int tx_rd_cnt = 0;
    int tx_done_cnt = 0;
    logic [7:0] rx_exp[$];
    logic       tx_exp[$];
    logic [7:0] rx_e;
    logic       tx_e;

    usbfs_packet_sequencer dut (
        .clk(clk), .rst(rst),
        .rx_sta(rx_sta), .rx_ena(rx_ena), .rx_bit(rx_bit), .rx_fin(rx_fin),
        .tx_sta(tx_sta), .tx_req(tx_req), .tx_bit(tx_bit), .tx_fin(tx_fin),
        .rx_pkt_sta(rx_pkt_sta), .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
        .rx_pkt_end(rx_pkt_end), .rx_pkt_ok(rx_pkt_ok), .rx_pkt_len(rx_pkt_len),
        .tx_go(tx_go), .tx_data(tx_data), .tx_empty(tx_empty),
        .tx_rd(tx_rd), .tx_done(tx_done), .busy(busy)
    );

    always #8 clk = ~clk;

    // RX scoreboard: every byte-valid pulse must match the next queued byte
    always @(negedge clk) begin
        if (rx_byte_valid === 1'b1) begin
            checks++;
            assert (rx_exp.size() != 0) else begin
                failures++;
                $error("FAIL rx_byte_unexpected observed=%0h expected=none", rx_byte);
            end
            if (rx_exp.size() != 0) begin
                rx_e = rx_exp.pop_front();
                checks++;
                assert (rx_byte === rx_e) else begin
                    failures++;
                    $error("FAIL rx_byte observed=%0h expected=%0h", rx_byte, rx_e);
                end
            end
        end
        if (tx_rd === 1'b1)   tx_rd_cnt++;
        if (tx_done === 1'b1) tx_done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            rx_ena = 1'b1;
            rx_bit = data[i];
            step();
        end
        rx_ena = 1'b0;
        rx_bit = 1'b0;
    endtask

    task automatic pulse_rx_sta();
        rx_sta = 1'b1;
        step();
        rx_sta = 1'b0;
    endtask

    task automatic pulse_rx_fin();
        rx_fin = 1'b1;
        step();
        rx_fin = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_sta = 0; rx_ena = 0; rx_bit = 0; rx_fin = 0;
        tx_req = 0; tx_go = 0; tx_data = 8'h00; tx_empty = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("reset_flags", {tx_sta, tx_bit, tx_fin, rx_pkt_sta, rx_byte_valid,
                            rx_pkt_end, rx_pkt_ok, tx_rd, tx_done, busy}, 32'h0);
        chk("reset_byte", rx_byte, 32'h0);
        chk("reset_len", rx_pkt_len, 32'h0);

        // tx_req outside TX is answered with tx_fin
        tx_req = 1'b1; step(); tx_req = 1'b0;
        chk("idle_req_fin", tx_fin, 1);
        step();
        chk("idle_fin_pulse", tx_fin, 0);

        // two good bytes, answered at F+2
        pulse_rx_sta();
        chk("p1_pkt_sta", rx_pkt_sta, 1);
        chk("p1_busy", busy, 1);
        rx_exp.push_back(8'hA5);
        rx_exp.push_back(8'h3C);
        send_bits(8'hA5, 8);
        send_bits(8'h3C, 8);
        pulse_rx_fin();
        chk("p1_end", rx_pkt_end, 1);
        chk("p1_ok", rx_pkt_ok, 1);
        chk("p1_len", rx_pkt_len, 2);
        step();
        chk("p1_no_sta_f2", tx_sta, 0);
        tx_go = 1'b1; step(); tx_go = 1'b0;
        chk("p1_tx_sta_f3", tx_sta, 1);
        chk("p1_len_hold", rx_pkt_len, 2);

        tx_data = 8'h80; tx_empty = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_exp.push_back(i == 7);
            tx_req = 1'b1; step(); tx_req = 1'b0;
            tx_empty = 1'b1;
            tx_e = tx_exp.pop_front();
            chk($sformatf("tx_bit%0d", i), tx_bit, tx_e);
            chk($sformatf("tx_nofin%0d", i), tx_fin, 0);
            step();
            chk($sformatf("tx_hold%0d", i), tx_bit, tx_e);
        end
        tx_req = 1'b1; step(); tx_req = 1'b0;
        chk("tx_fin9", tx_fin, 1);
        chk("tx_fin_bit", tx_bit, 0);
        step();
        chk("tx_done", tx_done, 1);
        chk("tx_idle_busy", busy, 0);
        step();
        chk("tx_done_pulse", tx_done, 0);
        chk("tx_rd_count", tx_rd_cnt, 1);
        chk("tx_done_count", tx_done_cnt, 1);

        // 11 bits: one byte plus misalignment, tx_go only at F+3
        pulse_rx_sta();
        rx_exp.push_back(8'h5A);
        send_bits(8'h5A, 8);
        send_bits(8'h05, 3);
        pulse_rx_fin();
        chk("p2_end", rx_pkt_end, 1);
        chk("p2_ok", rx_pkt_ok, 0);
        chk("p2_len", rx_pkt_len, 1);
        step();
        chk("p2_busy_f2", busy, 1);
        step();
        tx_go = 1'b1;
        chk("p2_busy_f3", busy, 0);
        step(); tx_go = 1'b0;
        chk("p2_no_tx_sta", tx_sta, 0);
        chk("p2_stay_idle", busy, 0);

        // aborted packet restarts byte assembly from bit 0
        pulse_rx_sta();
        send_bits(8'h1F, 5);
        pulse_rx_sta();
        chk("p3_abort_end", rx_pkt_end, 1);
        chk("p3_abort_ok", rx_pkt_ok, 0);
        chk("p3_abort_sta", rx_pkt_sta, 1);
        chk("p3_abort_len", rx_pkt_len, 0);
        rx_exp.push_back(8'hC3);
        send_bits(8'hC3, 8);
        pulse_rx_fin();
        chk("p3_ok", rx_pkt_ok, 1);
        chk("p3_len", rx_pkt_len, 1);
        step(); step(); step();

        // reset in the middle of a transmission
        pulse_rx_sta();
        rx_exp.push_back(8'h11);
        send_bits(8'h11, 8);
        pulse_rx_fin();
        tx_go = 1'b1; step(); tx_go = 1'b0;
        chk("p4_tx_sta", tx_sta, 1);
        tx_data = 8'hFF; tx_empty = 1'b0;
        tx_req = 1'b1; step();
        tx_empty = 1'b1;
        step(); tx_req = 1'b0;
        chk("p4_tx_bit", tx_bit, 1);
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk("rst_flags", {tx_sta, tx_bit, tx_fin, rx_pkt_sta, rx_byte_valid,
                          rx_pkt_end, rx_pkt_ok, tx_rd, tx_done, busy}, 32'h0);
        chk("rst_byte", rx_byte, 32'h0);
        chk("rst_len", rx_pkt_len, 32'h0);
        step(); step(); step();
        chk("rst_no_done", tx_done_cnt, 1);
        chk("rst_idle", busy, 0);
        chk("rx_queue_empty", rx_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usbfs_packet_sequencer.md
USBFS_PACKET_SEQUENCER -- requirements
Module: usbfs_packet_sequencer

Interface
REQ-001 SHALL: clk  in  1  system clock, 60 MHz, shared with the bit-level transceiver.
REQ-002 SHALL: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL: rx_sta, rx_ena, rx_bit, rx_fin  in  1 each  pulses from the bit-level transceiver.
REQ-004 SHALL: tx_sta  out  1  pulse to the transceiver that starts a TX packet.
REQ-005 SHALL: tx_req  in  1  the transceiver requests the next TX bit.
REQ-006 SHALL: tx_bit, tx_fin  out  1 each  next TX bit and end-of-packet flag to the transceiver.
REQ-007 SHALL: rx_pkt_sta, rx_byte_valid  out  1 each  upstream RX packet-start and byte-valid pulses.
REQ-008 SHALL: rx_byte  out  8  received byte, valid when rx_byte_valid=1.
REQ-009 SHALL: rx_pkt_end, rx_pkt_ok  out  1 each  packet-end pulse and byte-alignment status.
REQ-010 SHALL: rx_pkt_len  out  11  byte count of the last packet.
REQ-011 SHALL: tx_go  in  1  upstream decides to answer the just-received packet.
REQ-012 SHALL: tx_data  in  8  first-word-fall-through TX byte.
REQ-013 SHALL: tx_empty  in  1  no more TX bytes.
REQ-014 SHALL: tx_rd  out  1  pop pulse for tx_data.
REQ-015 SHALL: tx_done, busy  out  1 each  TX-complete pulse and state!=IDLE.

Function
REQ-016 SHALL implement states IDLE, RX, WIN, TX, TXEND; all outputs are registered except busy.
REQ-017 SHALL treat every output pulse as 1 cycle wide.
REQ-018 SHALL, on rx_sta in IDLE/RX/WIN: clear the bit counter (3 bit) and the byte counter, enter RX, and pulse rx_pkt_sta on the next cycle.
REQ-019 SHALL, on rx_sta arriving while in RX (aborted packet, no rx_fin): pulse rx_pkt_end with rx_pkt_ok=0 in the same cycle as the new rx_pkt_sta.
REQ-020 SHALL, on each rx_ena in RX: shift the byte register as {rx_bit, sr[7:1]} (LSB first).
REQ-021 SHALL, on the 8th such bit: pulse rx_byte_valid with the completed byte one cycle later and increment the byte count, saturating at 2047.
REQ-022 SHALL, on rx_fin in RX at cycle F: pulse rx_pkt_end at F+1 with rx_pkt_ok = (bit counter==0 && byte count!=0), and enter WIN.
REQ-023 SHALL hold rx_pkt_len stable from the rx_pkt_end pulse until the next rx_pkt_sta.
REQ-024 SHALL keep WIN open for cycles F+1 and F+2: tx_go=1 in either cycle gives tx_sta=1 on the next cycle (F+2 or F+3, inside the transceiver's window) and enters TX.
REQ-025 SHALL return from WIN to IDLE at F+3 without tx_sta when no tx_go was seen; tx_go is ignored in every other state.
REQ-026 SHALL, on tx_req in TX with TX bit index 0 and tx_empty=0: load tx_data[7:1] into the shift register, set tx_bit<=tx_data[0], pulse tx_rd, and set index=1.
REQ-027 SHALL, on tx_req in TX with index 0 and tx_empty=1: pulse tx_fin (tx_bit<=0) and enter TXEND.
REQ-028 SHALL, on tx_req in TX with index != 0: set tx_bit<=shift[0], shift right, and increment the index (wraps 7->0).
REQ-029 SHALL make tx_bit/tx_fin valid in the cycle after tx_req; tx_bit holds until the next tx_req.
REQ-030 SHALL pulse tx_done one cycle after entering TXEND, then return to IDLE.
REQ-031 SHALL answer tx_req outside TX with a tx_fin pulse.
REQ-032 SHALL ignore rx_sta/rx_ena/rx_fin in TX/TXEND.
REQ-033 SHALL support a zero-byte payload: tx_empty=1 at the first tx_req gives immediate tx_fin.

Reset
REQ-034 SHALL, with rst=1 at a clk edge: force state IDLE, all counters 0, and every output 0 (tx_bit=0, rx_byte=0, rx_pkt_len=0) on the next cycle.
REQ-035 SHALL let rst mid-RX or mid-TX abort without a rx_pkt_end or tx_done pulse.

Verification
REQ-036 SHALL cover: rst for 2 cycles mid-TX -> all outputs 0, busy=0, no tx_done.
REQ-037 SHALL cover: rx_sta, 16 bits LSB-first of 0xA5 then 0x3C, rx_fin at F -> rx_byte_valid with A5 then 3C; rx_pkt_end at F+1 with ok=1, len=2.
REQ-038 SHALL cover: 11 bits then rx_fin -> one byte; rx_pkt_end with ok=0, len=1.
REQ-039 SHALL cover: tx_go at F+2, tx_data=0x80 then tx_empty -> tx_sta at F+3; tx_bit sequence 0,0,0,0,0,0,0,1; tx_fin on the 9th tx_req; one tx_rd pulse; tx_done.
REQ-040 SHALL cover: tx_go only at F+3 -> no tx_sta; busy=0 at F+3.
REQ-041 SHALL cover: rx_sta, 5 bits, then rx_sta -> rx_pkt_end (ok=0) and rx_pkt_sta in the same cycle; the next byte assembles from bit 0.
